// File: rtl/prog_loader_if.sv
// Byte-stream and program-memory load bus for prog_loader.
//   in_valid/in_data/in_ready : serial program byte stream (valid/ready)
//   pmem_we/pmem_addr/pmem_data : program memory load port
//   done/error/core_hold/words_loaded : loader status
// slave modport is the loader side, master modport the source/observer side.
interface prog_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        pmem_we;
  logic [7:0]  pmem_addr;
  logic [11:0] pmem_data;
  logic        done;
  logic        error;
  logic        core_hold;
  logic [7:0]  words_loaded;

  modport slave (
    input  in_valid, in_data,
    output in_ready, pmem_we, pmem_addr, pmem_data, done, error, core_hold, words_loaded
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, pmem_we, pmem_addr, pmem_data, done, error, core_hold, words_loaded
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: parses a framed byte stream (0xA5, N, N x {HI, LO}, checksum)
// and writes N 12-bit instruction words into program memory, holding the core
// until a frame with a valid checksum has been loaded.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : prog_loader_if.slave (byte stream in, memory load port and status out)
module prog_loader #(
  parameter int unsigned DEPTH = 10
) (
  input  logic          clk,
  input  logic          rst,
  prog_loader_if.slave  bus
);

  localparam logic [7:0] Header = 8'hA5;
  localparam logic [7:0] DepthB = DEPTH[7:0];

  typedef enum logic [2:0] {StIdle, StLen, StHi, StLo, StCsum, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  len_q, len_d;
  logic [3:0]  hi_q, hi_d;
  logic        we_q, we_d;
  logic [7:0]  addr_q, addr_d;
  logic [11:0] data_q, data_d;
  logic        error_q, error_d;
  logic [7:0]  words_q, words_d;

  logic accept;

  assign bus.in_ready     = !rst && (state_q != StDone);
  assign accept           = bus.in_valid && bus.in_ready;
  assign bus.pmem_we      = we_q;
  assign bus.pmem_addr    = addr_q;
  assign bus.pmem_data    = data_q;
  assign bus.done         = (state_q == StDone);
  assign bus.core_hold    = (state_q != StDone);
  assign bus.error        = error_q;
  assign bus.words_loaded = words_q;

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    len_d   = len_q;
    hi_d    = hi_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    error_d = error_q;
    words_d = words_q;

    if (accept) begin
      unique case (state_q)
        StIdle: begin
          // Anything but the header is line noise and is dropped.
          if (bus.in_data == Header) begin
            state_d = StLen;
            error_d = 1'b0;
            words_d = 8'd0;
            sum_d   = 8'd0;
          end
        end
        StLen: begin
          if (bus.in_data != 8'd0 && bus.in_data <= DepthB) begin
            state_d = StHi;
            sum_d   = bus.in_data;
            len_d   = bus.in_data;
            idx_d   = 8'd0;
          end else begin
            state_d = StIdle;
            error_d = 1'b1;
          end
        end
        StHi: begin
          if (bus.in_data[7:4] == 4'd0) begin
            state_d = StLo;
            hi_d    = bus.in_data[3:0];
            sum_d   = sum_q + bus.in_data;
          end else begin
            state_d = StIdle;
            error_d = 1'b1;
          end
        end
        StLo: begin
          we_d    = 1'b1;
          addr_d  = idx_q;
          data_d  = {hi_q, bus.in_data};
          idx_d   = idx_q + 8'd1;
          words_d = words_q + 8'd1;
          sum_d   = sum_q + bus.in_data;
          // idx_q < N-1 is the same as idx_q+1 != N since idx_q < N here.
          state_d = (idx_q + 8'd1 != len_q) ? StHi : StCsum;
        end
        StCsum: begin
          if (bus.in_data == sum_q) begin
            state_d = StDone;
          end else begin
            state_d = StIdle;
            error_d = 1'b1;
          end
        end
        default: ;  // StDone never accepts
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sum_q   <= 8'd0;
      idx_q   <= 8'd0;
      len_q   <= 8'd0;
      hi_q    <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 8'd0;
      data_q  <= 12'd0;
      error_q <= 1'b0;
      words_q <= 8'd0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      hi_q    <= hi_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      error_q <= error_d;
      words_q <= words_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (DEPTH = 10).
module tb_prog_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prog_loader_if bus ();

  prog_loader #(.DEPTH(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Write log: every cycle with pmem_we high is recorded once.
  int          wr_total = 0;
  logic [7:0]  log_a [0:1023];
  logic [11:0] log_d [0:1023];

  always @(negedge clk) begin
    if (bus.pmem_we === 1'b1) begin
      log_a[wr_total] <= bus.pmem_addr;
      log_d[wr_total] <= bus.pmem_data;
      wr_total        <= wr_total + 1;
    end
  end

  logic [7:0] fq[$];

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    logic r;
    bus.in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    forever begin
      @(negedge clk); r = bus.in_ready;
      @(posedge clk); #1;
      if (r) break;
      n++;
      if (n >= 50) begin
        total++; bad++;
        $display("FAIL accept_timeout byte=%02h not accepted within 50 cycles", b);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_fq(input int maxgap);
    foreach (fq[i]) send_byte(fq[i], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    @(posedge clk); #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    total++; if (bus.pmem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", bus.pmem_we); end
    total++; if (bus.pmem_addr !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h exp=00", bus.pmem_addr); end
    total++; if (bus.pmem_data !== 12'h000) begin bad++; $display("FAIL reset_data got=%h exp=000", bus.pmem_data); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b exp=0", bus.error); end
    total++; if (bus.core_hold !== 1'b1) begin bad++; $display("FAIL reset_hold got=%b exp=1", bus.core_hold); end
    total++; if (bus.words_loaded !== 8'd0) begin bad++; $display("FAIL reset_words got=%0d exp=0", bus.words_loaded); end
    rst = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_nominal(input int maxgap);
    int base;
    do_reset();
    base = wr_total;
    fq = '{8'hA5, 8'h02, 8'h01, 8'h23, 8'h04, 8'h56, 8'h80};
    send_fq(maxgap);
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL nom_done gap=%0d got=%b exp=1", maxgap, bus.done); end
    total++; if (bus.core_hold !== 1'b0) begin bad++; $display("FAIL nom_hold got=%b exp=0", bus.core_hold); end
    total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL nom_error got=%b exp=0", bus.error); end
    total++; if (bus.words_loaded !== 8'd2) begin bad++; $display("FAIL nom_words got=%0d exp=2", bus.words_loaded); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL nom_ready got=%b exp=0", bus.in_ready); end
    total++; if (wr_total - base !== 2) begin bad++; $display("FAIL nom_wr_count got=%0d exp=2", wr_total - base); end
    total++; if (log_a[base] !== 8'd0 || log_d[base] !== 12'h123) begin bad++;
      $display("FAIL nom_wr0 got=%h@%0d exp=123@0", log_d[base], log_a[base]); end
    total++; if (log_a[base+1] !== 8'd1 || log_d[base+1] !== 12'h456) begin bad++;
      $display("FAIL nom_wr1 got=%h@%0d exp=456@1", log_d[base+1], log_a[base+1]); end
    total++; if (bus.pmem_addr !== 8'd1 || bus.pmem_data !== 12'h456) begin bad++;
      $display("FAIL nom_hold_last got=%h@%0d exp=456@1", bus.pmem_data, bus.pmem_addr); end
    // Bytes offered in DONE must be ignored.
    base = wr_total;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    repeat (3) begin
      bus.in_data = bus.in_data + 8'd1;
      @(posedge clk); #1;
    end
    bus.in_data = 8'hA5;
    repeat (4) begin @(posedge clk); #1; end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.done !== 1'b1 || bus.in_ready !== 1'b0) begin bad++;
      $display("FAIL done_sticky done=%b ready=%b exp done=1 ready=0", bus.done, bus.in_ready); end
    total++; if (wr_total - base !== 0) begin bad++; $display("FAIL done_no_write got=%0d exp=0", wr_total - base); end
    total++; if (bus.words_loaded !== 8'd2) begin bad++; $display("FAIL done_words got=%0d exp=2", bus.words_loaded); end
  endtask

  task automatic test_bad_csum();
    int base;
    do_reset();
    base = wr_total;
    fq = '{8'hA5, 8'h02, 8'h01, 8'h23, 8'h04, 8'h56, 8'h81};
    send_fq(0);
    total++; if (bus.error !== 1'b1) begin bad++; $display("FAIL csum_error got=%b exp=1", bus.error); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL csum_done got=%b exp=0", bus.done); end
    total++; if (bus.core_hold !== 1'b1) begin bad++; $display("FAIL csum_hold got=%b exp=1", bus.core_hold); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL csum_ready got=%b exp=1", bus.in_ready); end
    total++; if (wr_total - base !== 2) begin bad++; $display("FAIL csum_wr_count got=%0d exp=2", wr_total - base); end
    send_byte(8'hA5, 0);
    total++; if (bus.error !== 1'b0 || bus.words_loaded !== 8'd0) begin bad++;
      $display("FAIL csum_hdr_clear error=%b words=%0d exp 0/0", bus.error, bus.words_loaded); end
    fq = '{8'h01, 8'h03, 8'h21, 8'h25};  // 01+03+21 = 25
    send_fq(0);
    total++; if (bus.done !== 1'b1 || bus.error !== 1'b0) begin bad++;
      $display("FAIL csum_recover done=%b error=%b exp 1/0", bus.done, bus.error); end
    total++; if (log_d[wr_total-1] !== 12'h321 || log_a[wr_total-1] !== 8'd0) begin bad++;
      $display("FAIL csum_recover_wr got=%h@%0d exp=321@0", log_d[wr_total-1], log_a[wr_total-1]); end
  endtask

  task automatic test_len_bounds();
    int base;
    logic [7:0] s;
    logic [3:0] h;
    do_reset();
    base = wr_total;
    fq = '{8'hA5, 8'h0B};
    send_fq(0);
    total++; if (bus.error !== 1'b1) begin bad++; $display("FAIL len_big_error got=%b exp=1", bus.error); end
    fq = '{8'hA5, 8'h00};
    send_fq(0);
    total++; if (bus.error !== 1'b1) begin bad++; $display("FAIL len_zero_error got=%b exp=1", bus.error); end
    @(posedge clk); #1;
    total++; if (wr_total - base !== 0) begin bad++; $display("FAIL len_no_write got=%0d exp=0", wr_total - base); end
    base = wr_total;
    fq = '{8'hA5, 8'h0A};
    s = 8'h0A;
    for (int i = 0; i < 10; i++) begin
      fq.push_back(8'(i));
      fq.push_back(8'(i * 17));
      s = s + 8'(i) + 8'(i * 17);
    end
    fq.push_back(s);
    send_fq(0);
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL len_max_done got=%b exp=1", bus.done); end
    total++; if (bus.words_loaded !== 8'd10) begin bad++; $display("FAIL len_max_words got=%0d exp=10", bus.words_loaded); end
    total++; if (wr_total - base !== 10) begin bad++; $display("FAIL len_max_wr_count got=%0d exp=10", wr_total - base); end
    for (int i = 0; i < 10; i++) begin
      h = 4'(i);
      total++;
      if (log_a[base+i] !== 8'(i) || log_d[base+i] !== {h, 8'(i * 17)}) begin bad++;
        $display("FAIL len_max_wr%0d got=%h@%0d exp=%h@%0d", i, log_d[base+i], log_a[base+i],
                 {h, 8'(i * 17)}, i); end
    end
  endtask

  task automatic test_bad_hi();
    int base;
    do_reset();
    base = wr_total;
    fq = '{8'hA5, 8'h01, 8'hF1};
    send_fq(0);
    total++; if (bus.error !== 1'b1) begin bad++; $display("FAIL hi_error got=%b exp=1", bus.error); end
    @(posedge clk); #1;
    total++; if (wr_total - base !== 0) begin bad++; $display("FAIL hi_no_write got=%0d exp=0", wr_total - base); end
    // Back in IDLE: a non-header byte is dropped, then a full frame loads.
    fq = '{8'h01, 8'hA5, 8'h01, 8'h00, 8'h07, 8'h08};
    send_fq(0);
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL hi_recover_done got=%b exp=1", bus.done); end
    total++; if (log_d[wr_total-1] !== 12'h007) begin bad++;
      $display("FAIL hi_recover_wr got=%h exp=007", log_d[wr_total-1]); end
  endtask

  task automatic test_reset_midframe();
    int base;
    do_reset();
    base = wr_total;
    fq = '{8'h3C, 8'hA5, 8'h02, 8'h01};
    send_fq(0);
    do_reset();
    fq = '{8'hA5, 8'h01, 8'h0F, 8'hFF, 8'h0F};
    send_fq(0);
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL mid_done got=%b exp=1", bus.done); end
    total++; if (wr_total - base !== 1) begin bad++; $display("FAIL mid_wr_count got=%0d exp=1", wr_total - base); end
    total++; if (log_a[base] !== 8'd0 || log_d[base] !== 12'hFFF) begin bad++;
      $display("FAIL mid_wr got=%h@%0d exp=fff@0", log_d[base], log_a[base]); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_nominal(0);
    test_bad_csum();
    test_len_bounds();
    test_bad_hi();
    test_reset_midframe();
    test_nominal(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
